writeback_unit: RTL and testbench

Merges the two result streams of the 18-bit datapath into the single write port of the 32×18 register file (WE3/A3/WD3). ALU results are single-cycle and never stall. Memory-load results arrive through a valid/ready handshake and are buffered in a small FIFO that drains whenever the port is idle. The block also kills stale queued loads overtaken by newer ALU writes, and exports a per-register pending mask so decode can stall on load-use hazards.

---
 rtl/writeback_unit.sv | 131 +++++++++++++
 tb/tb_writeback_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Merges single-cycle ALU results and buffered load results onto the single
// register-file write port, killing queued loads overtaken by newer ALU writes.
module writeback_unit #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 18,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   output logic          wb_we,
   output logic [AW-1:0] wb_addr,
   output logic [DW-1:0] wb_data,
   output logic [31:0]   pend_mask
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic          live;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        fifo_q [DEPTH];
   logic [PW-1:0] rptr_q;
   logic [PW-1:0] wptr_q;
   logic [CW-1:0] count_q;

   logic          alu_win_c;
   logic          push_c;
   logic          pop_c;
   logic          push_live_c;
   logic          wr_en_c;
   logic [AW-1:0] wr_addr_c;
   logic [DW-1:0] wr_data_c;
   entry_t        head_c;

   assign mem_ready = !rst && (count_q < CW'(DEPTH));

   // Port arbitration: ALU always wins; otherwise drain the head, live or dead.
   always_comb begin
      alu_win_c   = 1'b0;
      push_c      = 1'b0;
      pop_c       = 1'b0;
      push_live_c = 1'b0;
      wr_en_c     = 1'b0;
      wr_addr_c   = '0;
      wr_data_c   = '0;
      head_c      = fifo_q[rptr_q];

      alu_win_c   = alu_valid && (alu_rd != '0);
      push_c      = mem_valid && mem_ready && (mem_rd != '0);
      // A same-edge load to the ALU target is program-older, so it is born dead.
      push_live_c = !(alu_win_c && (mem_rd == alu_rd));
      pop_c       = !alu_win_c && (count_q != '0);

      if (alu_win_c) begin
         wr_en_c   = 1'b1;
         wr_addr_c = alu_rd;
         wr_data_c = alu_data;
      end else if (pop_c && head_c.live) begin
         wr_en_c   = 1'b1;
         wr_addr_c = head_c.rd;
         wr_data_c = head_c.data;
      end
   end

   // Pending mask: popped and killed entries are marked dead, so live alone is enough.
   always_comb begin
      pend_mask = '0;
      for (int unsigned r = 1; r < 32; r++) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_q[PW'(i)].live && (fifo_q[PW'(i)].rd == AW'(r))) begin
               pend_mask[r] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         wb_we   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[PW'(i)].live <= 1'b0;
         end
      end else begin
         wb_we <= wr_en_c;
         if (wr_en_c) begin
            wb_addr <= wr_addr_c;
            wb_data <= wr_data_c;
         end

         // Write-after-write kill of queued loads to the ALU destination.
         if (alu_win_c) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (fifo_q[PW'(i)].rd == alu_rd) begin
                  fifo_q[PW'(i)].live <= 1'b0;
               end
            end
         end

         if (pop_c) begin
            fifo_q[rptr_q].live <= 1'b0;
            rptr_q              <= rptr_q + PW'(1);
         end

         if (push_c) begin
            fifo_q[wptr_q].live <= push_live_c;
            fifo_q[wptr_q].rd   <= mem_rd;
            fifo_q[wptr_q].data <= mem_data;
            wptr_q              <= wptr_q + PW'(1);
         end

         count_q <= count_q + CW'(push_c) - CW'(pop_c);
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed-vector bench for writeback_unit with a shadow register file fed
// from the write port.
module tb_writeback_unit;

   localparam int unsigned DW = 18;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_rd;
   logic [DW-1:0] mem_data;
   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [31:0]   pend_mask;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] rf [32];
   int            dead_load_writes = 0;
   int            flushed_writes   = 0;
   logic          watch_flush      = 1'b0;

   writeback_unit #(.DEPTH(4), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .pend_mask (pend_mask)
   );

   always #5 clk = ~clk;

   // Shadow register file commits on the edge after wb_we is presented.
   always @(posedge clk) begin
      if (wb_we) begin
         rf[wb_addr] <= wb_data;
         if (wb_data == 18'h33333) dead_load_writes++;
         if (watch_flush && (wb_addr >= 5'd10) && (wb_addr <= 5'd12)) flushed_writes++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_mask;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 18'h3FFFF;

      // Reset held with a load offered
      tick(); tick();
      check("rst_mem_ready", 32'(mem_ready), 32'd0);
      check("rst_wb_we",     32'(wb_we),     32'd0);
      check("rst_wb_addr",   32'(wb_addr),   32'd0);
      check("rst_wb_data",   32'(wb_data),   32'd0);
      check("rst_pend",      pend_mask,      32'd0);
      rst = 1'b0; mem_valid = 1'b0;
      tick();
      check("post_rst_ready", 32'(mem_ready), 32'd1);
      check("post_rst_pend",  pend_mask,      32'd0);
      check("post_rst_we",    32'(wb_we),     32'd0);

      // ALU path and r0 suppression
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 18'h2A5A1;
      tick();
      check("alu_we",   32'(wb_we),   32'd1);
      check("alu_addr", 32'(wb_addr), 32'd3);
      check("alu_data", 32'(wb_data), 32'h2A5A1);
      alu_rd = 5'd0; alu_data = 18'h3FFFF;
      tick();
      check("alu_r0_we",   32'(wb_we),   32'd0);
      check("alu_r0_addr", 32'(wb_addr), 32'd3);
      check("alu_r0_data", 32'(wb_data), 32'h2A5A1);

      // Fill FIFO behind a busy ALU, then drain
      alu_rd = 5'd1; alu_data = 18'h00001;
      for (int i = 0; i < 4; i++) begin
         check("fill_ready", 32'(mem_ready), 32'd1);
         mem_valid = 1'b1; mem_rd = AW'(5 + i); mem_data = DW'(18'h00100 + i);
         tick();
      end
      mem_valid = 1'b0;
      check("full_ready", 32'(mem_ready), 32'd0);
      check("full_pend",  pend_mask,      32'h1E0);
      check("busy_addr",  32'(wb_addr),   32'd1);
      alu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_mask = '0;
         for (int j = i + 1; j < 4; j++) exp_mask[5 + j] = 1'b1;
         check("drain_we",    32'(wb_we),     32'd1);
         check("drain_addr",  32'(wb_addr),   32'(5 + i));
         check("drain_data",  32'(wb_data),   32'h100 + 32'(i));
         check("drain_pend",  pend_mask,      exp_mask);
         check("drain_ready", 32'(mem_ready), 32'd1);
      end
      tick();
      check("drained_we", 32'(wb_we), 32'd0);

      // Kill: queued load to r9 overtaken by a younger ALU write
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 18'h00002;
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 18'h11111;
      tick();
      mem_valid = 1'b0;
      check("kill_pend_set", pend_mask, 32'h200);
      alu_rd = 5'd9; alu_data = 18'h22222;
      tick();
      check("kill_alu_addr", 32'(wb_addr), 32'd9);
      check("kill_alu_data", 32'(wb_data), 32'h22222);
      check("kill_pend_clr", pend_mask,    32'd0);
      alu_valid = 1'b0;
      tick();
      check("kill_dead_pop_we", 32'(wb_we), 32'd0);
      tick();
      check("kill_r9_final", 32'(rf[9]), 32'h22222);

      // Same-edge ALU and load to r9: load enters dead
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 18'h0ABCD;
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 18'h33333;
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0;
      check("same_edge_data", 32'(wb_data), 32'h0ABCD);
      check("same_edge_pend", pend_mask,    32'd0);
      tick();
      check("same_edge_pop_we", 32'(wb_we), 32'd0);
      tick();
      check("same_edge_r9",     32'(rf[9]),          32'h0ABCD);
      check("same_edge_nowr",   32'(dead_load_writes), 32'd0);

      // Load to r0 is dropped
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 18'h12345;
      tick();
      mem_valid = 1'b0;
      check("r0_pend", pend_mask,  32'd0);
      check("r0_we1",  32'(wb_we), 32'd0);
      tick();
      check("r0_we2",  32'(wb_we), 32'd0);
      check("r0_rf",   32'(rf[0]), 32'd0);

      // Reset mid-drain discards queued loads and the sampled ALU write
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 18'h00003;
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1'b1; mem_rd = AW'(10 + i); mem_data = DW'(18'h3A000 + i);
         tick();
      end
      mem_valid = 1'b0;
      check("mid_pend", pend_mask, 32'h1C00);
      watch_flush = 1'b1;
      rst = 1'b1; alu_rd = 5'd4; alu_data = 18'h15555;
      tick();
      check("mid_rst_we",    32'(wb_we),     32'd0);
      check("mid_rst_addr",  32'(wb_addr),   32'd0);
      check("mid_rst_pend",  pend_mask,      32'd0);
      check("mid_rst_ready", 32'(mem_ready), 32'd0);
      rst = 1'b0; alu_valid = 1'b0;
      tick();
      check("mid_post_ready", 32'(mem_ready), 32'd1);
      check("mid_post_we",    32'(wb_we),     32'd0);
      tick(); tick(); tick();
      check("mid_no_flush_wr", 32'(flushed_writes), 32'd0);
      check("mid_r4_untouched", 32'(rf[4]),         32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
